// File: rtl/prng_dice_roller.sv
// prng_dice_roller: debounced push-button dice roller fed by the PRNG byte stream.
// A press plays a short animation, samples rand_in, reduces it to 1..FACES by
// repeated subtraction and holds the resulting face for the 7-segment decoder.
//
// Ports:
//   CLK      in   system clock, posedge
//   reset    in   asynchronous active-high reset
//   EN       in   synchronous enable; low returns to IDLE and clears outputs
//   rand_in  in   [7:0] random byte from the mux stage
//   roll_btn in   raw asynchronous push-button, active high
//   face     out  [3:0] animation face (ROLL), result (HOLD), else 0
//   valid    out  high while a final result is held
//   busy     out  high in ROLL and REDUCE
//   done     out  one-cycle pulse on entry to HOLD
module prng_dice_roller #(
  parameter logic [3:0]  FACES           = 4'd6,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [23:0] STEP_CYCLES     = 24'd1_000_000,
  parameter logic [3:0]  ANIM_STEPS      = 4'd8
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       EN,
  input  logic [7:0] rand_in,
  input  logic       roll_btn,
  output logic [3:0] face,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned FACE_W = 4;
  localparam int unsigned DB_W   = 16;
  localparam int unsigned CYC_W  = 24;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned WORK_W = 8;

  typedef enum logic [1:0] {IDLE, ROLL, REDUCE, HOLD} state_t;

  // Button synchronizer and debouncer
  logic            sync1;
  logic            sync2;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            roll_req;

  // The counter tracks consecutive cycles the synchronized level disagrees with
  // the debounced level; any agreement restarts it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= roll_btn;
      sync2 <= sync1;
      if (!EN) begin
        db_level <= 1'b0;
        db_prev  <= 1'b0;
        db_cnt   <= '0;
      end else begin
        db_prev <= db_level;
        if (sync2 == db_level) begin
          db_cnt <= '0;
        end else if (db_cnt == DEBOUNCE_CYCLES - DB_W'(1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end
  end

  // One-cycle request in the cycle after the debounced level rises
  assign roll_req = db_level & ~db_prev;

  // FSM and datapath registers
  state_t             state;
  state_t             state_n;
  logic [FACE_W-1:0]  face_n;
  logic               valid_n;
  logic               busy_n;
  logic               done_n;
  logic [STEP_W-1:0]  step;
  logic [STEP_W-1:0]  step_n;
  logic [CYC_W-1:0]   cyc;
  logic [CYC_W-1:0]   cyc_n;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  work_n;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      face  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      step  <= '0;
      cyc   <= '0;
      work  <= '0;
    end else begin
      state <= state_n;
      face  <= face_n;
      valid <= valid_n;
      busy  <= busy_n;
      done  <= done_n;
      step  <= step_n;
      cyc   <= cyc_n;
      work  <= work_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    face_n  = face;
    valid_n = valid;
    busy_n  = busy;
    done_n  = 1'b0;
    step_n  = step;
    cyc_n   = cyc;
    work_n  = work;

    if (!EN) begin
      state_n = IDLE;
      face_n  = '0;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      step_n  = '0;
      cyc_n   = '0;
      work_n  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          face_n  = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          if (roll_req) begin
            state_n = ROLL;
            face_n  = FACE_W'(1);
            busy_n  = 1'b1;
            step_n  = '0;
            cyc_n   = '0;
          end
        end
        ROLL: begin
          if (cyc == STEP_CYCLES - CYC_W'(1)) begin
            cyc_n = '0;
            if (step == ANIM_STEPS - STEP_W'(1)) begin
              // Last ROLL edge: sample the random byte
              work_n  = rand_in;
              state_n = REDUCE;
              face_n  = '0;
            end else begin
              step_n = step + STEP_W'(1);
              face_n = (face == FACES) ? FACE_W'(1) : face + FACE_W'(1);
            end
          end else begin
            cyc_n = cyc + CYC_W'(1);
          end
        end
        REDUCE: begin
          if (work >= WORK_W'(FACES)) begin
            work_n = work - WORK_W'(FACES);
          end else begin
            // work < FACES <= 15, so the low nibble is the whole remainder
            face_n  = work[3:0] + FACE_W'(1);
            valid_n = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (roll_req) begin
            state_n = ROLL;
            face_n  = FACE_W'(1);
            valid_n = 1'b0;
            busy_n  = 1'b1;
            step_n  = '0;
            cyc_n   = '0;
          end
        end
        default: begin
          state_n = IDLE;
          face_n  = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          step_n  = '0;
          cyc_n   = '0;
          work_n  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prng_dice_roller.sv
// Bench for prng_dice_roller: two instances (FACES=6 and FACES=15) share all
// inputs. A behavioural model predicts every output each cycle; directed
// scenarios add literal expectations for latencies and result faces.
module tb_prng_dice_roller;

  localparam int DEB      = 4;
  localparam int STEP     = 3;
  localparam int ANIM     = 2;
  localparam int ROLL_LEN = STEP * ANIM;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       EN = 1'b1;
  logic [7:0] rand_in = 8'd0;
  logic       roll_btn = 1'b0;

  logic [3:0] face_a, face_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  prng_dice_roller #(.FACES(4'd6), .DEBOUNCE_CYCLES(16'd4), .STEP_CYCLES(24'd3),
                     .ANIM_STEPS(4'd2)) dut_a (
    .CLK(CLK), .reset(reset), .EN(EN), .rand_in(rand_in), .roll_btn(roll_btn),
    .face(face_a), .valid(valid_a), .busy(busy_a), .done(done_a));

  prng_dice_roller #(.FACES(4'd15), .DEBOUNCE_CYCLES(16'd4), .STEP_CYCLES(24'd3),
                     .ANIM_STEPS(4'd2)) dut_b (
    .CLK(CLK), .reset(reset), .EN(EN), .rand_in(rand_in), .roll_btn(roll_btn),
    .face(face_b), .valid(valid_b), .busy(busy_b), .done(done_b));

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 rolling, 2 reducing, 3 holding
  int   fc [2] = '{6, 15};
  int   mode [2] = '{0, 0};
  int   el [2] = '{0, 0};
  int   red_el [2] = '{0, 0};
  int   r_cap [2] = '{0, 0};
  int   exp_face [2] = '{0, 0};
  logic exp_valid [2] = '{1'b0, 1'b0};
  logic exp_busy [2] = '{1'b0, 1'b0};
  logic exp_done [2] = '{1'b0, 1'b0};
  logic [1:0] rawd = 2'b00;
  logic m_db = 1'b0;
  logic press_nxt = 1'b0;
  logic win [$];

  task automatic model_outputs();
    for (int k = 0; k < 2; k++) begin
      exp_face[k]  = (mode[k] == 1) ? 1 + (el[k] / STEP) % fc[k] :
                     (mode[k] == 3) ? r_cap[k] % fc[k] + 1 : 0;
      exp_valid[k] = (mode[k] == 3);
      exp_busy[k]  = (mode[k] == 1) || (mode[k] == 2);
    end
  endtask

  task automatic model_step();
    logic synced, press, all_diff;
    if (reset) begin
      rawd = 2'b00; m_db = 1'b0; press_nxt = 1'b0; win.delete();
      for (int k = 0; k < 2; k++) begin
        mode[k] = 0; el[k] = 0; red_el[k] = 0; exp_done[k] = 1'b0;
      end
    end else begin
      synced = rawd[1];
      rawd = {rawd[0], roll_btn};
      press = press_nxt;
      press_nxt = 1'b0;
      for (int k = 0; k < 2; k++) exp_done[k] = 1'b0;
      if (!EN) begin
        m_db = 1'b0; win.delete();
        for (int k = 0; k < 2; k++) begin mode[k] = 0; el[k] = 0; end
      end else begin
        // debounced level flips after DEB enabled cycles of disagreement
        win.push_back(synced);
        if (win.size() > DEB) void'(win.pop_front());
        if (win.size() == DEB) begin
          all_diff = 1'b1;
          foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
          if (all_diff) begin
            m_db = ~m_db;
            win.delete();
            if (m_db) press_nxt = 1'b1;
          end
        end
        for (int k = 0; k < 2; k++) begin
          case (mode[k])
            0, 3: if (press) begin mode[k] = 1; el[k] = 0; end
            1: begin
              el[k]++;
              if (el[k] == ROLL_LEN) begin
                r_cap[k] = int'(rand_in); mode[k] = 2; red_el[k] = 0;
              end
            end
            default: begin
              red_el[k]++;
              if (red_el[k] == r_cap[k] / fc[k] + 1) begin
                mode[k] = 3; exp_done[k] = 1'b1;
              end
            end
          endcase
        end
      end
    end
    model_outputs();
  endtask

  initial forever begin
    @(posedge CLK or posedge reset);
    model_step();
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic seen_busy = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    chk("model_face_a", int'(face_a), exp_face[0]);
    chk("model_valid_a", int'(valid_a), int'(exp_valid[0]));
    chk("model_busy_a", int'(busy_a), int'(exp_busy[0]));
    chk("model_done_a", int'(done_a), int'(exp_done[0]));
    chk("model_face_b", int'(face_b), exp_face[1]);
    chk("model_valid_b", int'(valid_b), int'(exp_valid[1]));
    chk("model_busy_b", int'(busy_b), int'(exp_busy[1]));
    chk("model_done_b", int'(done_b), int'(exp_done[1]));
    if (busy_a) seen_busy = 1'b1;
    if (done_a) done_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic cond(input int what);
    case (what)
      0:       return busy_a;
      1:       return valid_a;
      default: return 1'b0;
    endcase
  endfunction

  // Advance until the condition holds; n = cycles taken. Timeout is a failure.
  task automatic wait_for(input int what, input int lim, output int n);
    n = 0;
    while (!cond(what) && n < lim) begin
      tick();
      n++;
    end
    if (!cond(what)) chk($sformatf("timeout_wait_%0d", what), 0, 1);
  endtask

  // Press, release at the start of ROLL, return the REDUCE length of instance a
  task automatic do_roll(input logic [7:0] r, output int red_n);
    int n;
    rand_in = r;
    roll_btn = 1'b1;
    wait_for(0, 20, n);
    roll_btn = 1'b0;
    ticks(ROLL_LEN);
    wait_for(1, 300, red_n);
  endtask

  function automatic int zeros_ok();
    return int'(face_a == 4'd0 && !valid_a && !busy_a && !done_a &&
                face_b == 4'd0 && !valid_b && !busy_b && !done_b);
  endfunction

  initial begin
    int n;
    // 1. reset, then async reset mid-clock with random inputs
    ticks(2);
    reset = 1'b0;
    chk("reset_state", zeros_ok(), 1);
    rand_in = 8'($urandom_range(0, 255));
    ticks(3);
    #2 reset = 1'b1;
    #1 chk("reset_async_idle", zeros_ok(), 1);
    tick();
    reset = 1'b0;
    ticks(3);
    chk("idle_after_reset", int'(busy_a), 0);

    // 2. bounce pattern: no request
    seen_busy = 1'b0;
    roll_btn = 1'b1; ticks(3);
    roll_btn = 1'b0; ticks(3);
    roll_btn = 1'b1; ticks(2);
    roll_btn = 1'b0; ticks(8);
    chk("bounce_no_busy", int'(seen_busy), 0);

    // steady press: busy 2 sync + 4 debounce + 1 request cycles later
    rand_in = 8'd200;
    roll_btn = 1'b1;
    wait_for(0, 20, n);
    chk("press_latency", n, 7);
    roll_btn = 1'b0;

    // 3. animation 1 then 2, REDUCE 34 cycles, face 3
    chk("roll_face_first", int'(face_a), 1);
    ticks(STEP);
    chk("roll_face_second", int'(face_a), 2);
    ticks(STEP);
    chk("reduce_face_zero", int'(face_a), 0);
    done_cnt = 0;
    wait_for(1, 300, n);
    chk("reduce_len_200", n, 34);
    chk("result_200_a", int'(face_a), 3);
    chk("result_200_b", int'(face_b), 6);
    chk("done_with_valid", int'(done_a), 1);
    chk("busy_low_in_hold", int'(busy_a), 0);
    tick();
    chk("done_one_cycle", int'(done_a), 0);
    chk("valid_held", int'(valid_a), 1);
    ticks(4);

    // 4. edge values
    do_roll(8'd5, n);
    chk("reduce_len_5", n, 1);
    chk("result_5_a", int'(face_a), 6);
    ticks(4);
    do_roll(8'd0, n);
    chk("result_0_a", int'(face_a), 1);
    chk("result_0_b", int'(face_b), 1);
    ticks(4);
    do_roll(8'd6, n);
    chk("reduce_len_6", n, 2);
    chk("result_6_a", int'(face_a), 1);
    chk("result_6_b", int'(face_b), 7);
    ticks(4);
    do_roll(8'd255, n);
    chk("reduce_len_255_a", n, 43);
    chk("result_255_a", int'(face_a), 4);
    chk("result_255_b", int'(face_b), 1);
    ticks(4);

    // 5. press during ROLL/REDUCE ignored; press in HOLD re-rolls
    rand_in = 8'd200;
    done_cnt = 0;
    roll_btn = 1'b1; ticks(8);
    roll_btn = 1'b0; ticks(8);
    roll_btn = 1'b1; ticks(8);
    roll_btn = 1'b0;
    wait_for(1, 100, n);
    ticks(10);
    chk("ignored_press_one_done", done_cnt, 1);
    rand_in = 8'd13;
    roll_btn = 1'b1;
    wait_for(0, 20, n);
    chk("reroll_valid_drops", int'(valid_a), 0);
    chk("reroll_face_one", int'(face_a), 1);
    roll_btn = 1'b0;
    ticks(ROLL_LEN);
    wait_for(1, 300, n);
    chk("result_13_a", int'(face_a), 2);
    chk("result_13_b", int'(face_b), 14);
    ticks(4);

    // 6. EN low during REDUCE, then reset during ROLL
    rand_in = 8'd200;
    roll_btn = 1'b1;
    wait_for(0, 20, n);
    roll_btn = 1'b0;
    ticks(ROLL_LEN + 3);
    chk("in_reduce_busy", int'(busy_a), 1);
    EN = 1'b0;
    tick();
    chk("en_low_zeros", zeros_ok(), 1);
    EN = 1'b1;
    ticks(8);
    roll_btn = 1'b1;
    wait_for(0, 20, n);
    roll_btn = 1'b0;
    ticks(2);
    #2 reset = 1'b1;
    #1 chk("reset_in_roll_zeros", zeros_ok(), 1);
    tick();
    reset = 1'b0;
    ticks(3);
    do_roll(8'd5, n);
    chk("after_reset_result_a", int'(face_a), 6);
    chk("after_reset_result_b", int'(face_b), 6);
    ticks(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
